// File: rtl/cpu_inst_fifo.sv
// Dual-slot instruction fetch queue between fetch and dual-issue decode.
// Accepts up to two fetched instructions per cycle and presents the two
// oldest entries combinationally. A flush empties the queue in one cycle.
module cpu_inst_fifo #(
  parameter int DEPTH = 8,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push_valid1,
  input  logic             push_valid2,
  input  logic [31:0]      push_inst1,
  input  logic [31:0]      push_inst2,
  input  logic [31:0]      push_pc1,
  input  logic [31:0]      push_pc2,
  input  logic [2:0]       push_except1,
  input  logic [2:0]       push_except2,
  output logic             full_stall,
  input  logic [1:0]       pop_cnt,
  output logic             out_valid1,
  output logic             out_valid2,
  output logic [31:0]      out_inst1,
  output logic [31:0]      out_inst2,
  output logic [31:0]      out_pc1,
  output logic [31:0]      out_pc2,
  output logic [2:0]       out_except1,
  output logic [2:0]       out_except2,
  output logic [PTR_W:0]   count
);

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [2:0]  exc;
  } entry_t;

  entry_t             mem_q [DEPTH];
  logic [PTR_W-1:0]   head_q, head_d, tail_q, tail_d;
  logic [PTR_W:0]     count_q, count_d;
  logic [PTR_W-1:0]   head_p1, tail_p1;
  logic               push_ok;
  logic [1:0]         push_n, pop_req, pop_eff;
  entry_t             rd1, rd2;

  // Stall only looks at registered occupancy: a same-cycle pop does not
  // free space until the next edge, so fetch needs two guaranteed slots.
  assign full_stall = (count_q > (PTR_W+1)'(DEPTH - 2));
  assign push_ok    = push_valid1 & ~full_stall;
  assign push_n     = {1'b0, push_ok} + {1'b0, push_ok & push_valid2};
  // pop_cnt=3 behaves like 2; requests beyond occupancy are clamped.
  assign pop_req    = (pop_cnt == 2'd3) ? 2'd2 : pop_cnt;
  assign pop_eff    = ({{(PTR_W-1){1'b0}}, pop_req} > count_q) ? count_q[1:0] : pop_req;
  assign head_p1    = head_q + PTR_W'(1);
  assign tail_p1    = tail_q + PTR_W'(1);

  // Next-state for pointers and occupancy; flush wins over push/pop.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + PTR_W'(pop_eff);
      tail_d  = tail_q + PTR_W'(push_n);
      count_d = count_q + (PTR_W+1)'(push_n) - (PTR_W+1)'(pop_eff);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage; contents are don't-care after reset, so no reset here.
  always_ff @(posedge clk) begin
    if (push_ok && !flush) begin
      mem_q[tail_q] <= '{inst: push_inst1, pc: push_pc1, exc: push_except1};
      if (push_valid2)
        mem_q[tail_p1] <= '{inst: push_inst2, pc: push_pc2, exc: push_except2};
    end
  end

  // Zero-latency read of the two oldest entries, zeroed when not present.
  always_comb begin
    rd1         = mem_q[head_q];
    rd2         = mem_q[head_p1];
    out_valid1  = (count_q != '0);
    out_valid2  = (count_q >= (PTR_W+1)'(2));
    out_inst1   = out_valid1 ? rd1.inst : '0;
    out_pc1     = out_valid1 ? rd1.pc   : '0;
    out_except1 = out_valid1 ? rd1.exc  : '0;
    out_inst2   = out_valid2 ? rd2.inst : '0;
    out_pc2     = out_valid2 ? rd2.pc   : '0;
    out_except2 = out_valid2 ? rd2.exc  : '0;
  end

  assign count = count_q;

endmodule
